// File: rtl/l2_tag_lookup_initiator.sv
// Requester side of the L2 tag bank flex-channel interface: issues one lookup or flush,
// gathers the bank's response beats and returns them as a single response beat.
`timescale 1ns/1ps
module l2_tag_lookup_initiator #(
    parameter int TAG_W   = 20,
    parameter int SET_W   = 8,
    parameter int WAY_W   = 3,
    parameter int STATE_W = 2,
    parameter int INV_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_flush,
    input  logic [TAG_W-1:0]   cmd_tag,
    input  logic [SET_W-1:0]   cmd_set,
    input  logic               cmd_state_en,
    input  logic               cmd_inv_en,
    input  logic [STATE_W-1:0] cmd_state,
    input  logic [INV_W-1:0]   cmd_inv,
    output logic               tag_in_valid,
    input  logic               tag_in_ready,
    output logic [TAG_W-1:0]   tag_in,
    output logic               set_in_valid,
    input  logic               set_in_ready,
    output logic [SET_W-1:0]   set_in,
    output logic               state_in_valid,
    input  logic               state_in_ready,
    output logic [STATE_W-1:0] state_in,
    output logic               inv_ack_cnt_in_valid,
    input  logic               inv_ack_cnt_in_ready,
    output logic [INV_W-1:0]   inv_ack_cnt_in,
    output logic               flush_in_valid,
    input  logic               flush_in_ready,
    input  logic               way_out_valid,
    output logic               way_out_ready,
    input  logic [WAY_W-1:0]   way_out,
    input  logic               state_out_valid,
    output logic               state_out_ready,
    input  logic [STATE_W-1:0] state_out,
    input  logic               inv_ack_cnt_out_valid,
    output logic               inv_ack_cnt_out_ready,
    input  logic [INV_W-1:0]   inv_ack_cnt_out,
    input  logic               tag_out_evict_valid,
    output logic               tag_out_evict_ready,
    input  logic [TAG_W-1:0]   tag_out_evict,
    input  logic               set_out_evict_valid,
    output logic               set_out_evict_ready,
    input  logic [SET_W-1:0]   set_out_evict,
    input  logic               state_out_evict_valid,
    output logic               state_out_evict_ready,
    input  logic [STATE_W-1:0] state_out_evict,
    input  logic               way_out_flush_valid,
    output logic               way_out_flush_ready,
    input  logic               tag_out_flush_valid,
    output logic               tag_out_flush_ready,
    input  logic               set_out_flush_valid,
    output logic               set_out_flush_ready,
    input  logic               state_out_flush_valid,
    output logic               state_out_flush_ready,
    input  logic               inv_ack_cnt_out_flush_valid,
    output logic               inv_ack_cnt_out_flush_ready,
    input  logic               flush_complete_valid,
    output logic               flush_complete_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WAY_W-1:0]   rsp_way,
    output logic [STATE_W-1:0] rsp_state,
    output logic [INV_W-1:0]   rsp_inv,
    output logic               rsp_state_vld,
    output logic               rsp_inv_vld,
    output logic               rsp_evict,
    output logic               rsp_timeout,
    output logic [TAG_W-1:0]   rsp_evict_tag,
    output logic [SET_W-1:0]   rsp_evict_set,
    output logic [STATE_W-1:0] rsp_evict_state,
    output logic [15:0]        rsp_flush_cnt
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FL_REQ, S_FL_DRAIN, S_RSP} state_t;

    state_t             state_q;
    logic               cmd_ready_q;
    logic               tag_v_q, set_v_q, st_v_q, inv_v_q, fl_v_q;
    logic               tag_v_d, set_v_d, st_v_d, inv_v_d;
    logic [TAG_W-1:0]   tag_q;
    logic [SET_W-1:0]   set_q;
    logic [STATE_W-1:0] st_q;
    logic [INV_W-1:0]   inv_q;
    logic               bank_rdy_q, drain_rdy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rsp_valid_q, timeout_q, state_vld_q, inv_vld_q;
    logic [WAY_W-1:0]   rsp_way_q;
    logic [STATE_W-1:0] rsp_state_q;
    logic [INV_W-1:0]   rsp_inv_q;
    logic [2:0]         ev_seen_q;
    logic [TAG_W-1:0]   ev_tag_q;
    logic [SET_W-1:0]   ev_set_q;
    logic [STATE_W-1:0] ev_state_q;
    logic [15:0]        flush_cnt_q;
    logic [4:0]         rec_ready;
    logic               any_rec;

    // A request channel stays pending until its own ready is sampled while valid.
    always_comb begin
        tag_v_d = tag_v_q & ~tag_in_ready;
        set_v_d = set_v_q & ~set_in_ready;
        st_v_d  = st_v_q  & ~state_in_ready;
        inv_v_d = inv_v_q & ~inv_ack_cnt_in_ready;
    end

    assign any_rec = way_out_flush_valid | tag_out_flush_valid | set_out_flush_valid |
                     state_out_flush_valid | inv_ack_cnt_out_flush_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            tag_v_q     <= 1'b0;
            set_v_q     <= 1'b0;
            st_v_q      <= 1'b0;
            inv_v_q     <= 1'b0;
            fl_v_q      <= 1'b0;
            tag_q       <= '0;
            set_q       <= '0;
            st_q        <= '0;
            inv_q       <= '0;
            bank_rdy_q  <= 1'b0;
            drain_rdy_q <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            state_vld_q <= 1'b0;
            inv_vld_q   <= 1'b0;
            rsp_way_q   <= '0;
            rsp_state_q <= '0;
            rsp_inv_q   <= '0;
            ev_seen_q   <= '0;
            ev_tag_q    <= '0;
            ev_set_q    <= '0;
            ev_state_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        tag_q       <= cmd_tag;
                        set_q       <= cmd_set;
                        st_q        <= cmd_state;
                        inv_q       <= cmd_inv;
                        cnt_q       <= '0;
                        timeout_q   <= 1'b0;
                        state_vld_q <= 1'b0;
                        inv_vld_q   <= 1'b0;
                        ev_seen_q   <= '0;
                        rsp_way_q   <= '0;
                        if (cmd_flush) begin
                            fl_v_q      <= 1'b1;
                            flush_cnt_q <= '0;
                            state_q     <= S_FL_REQ;
                        end else begin
                            tag_v_q <= 1'b1;
                            set_v_q <= 1'b1;
                            st_v_q  <= cmd_state_en;
                            inv_v_q <= cmd_inv_en;
                            state_q <= S_ISSUE;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    tag_v_q <= tag_v_d;
                    set_v_q <= set_v_d;
                    st_v_q  <= st_v_d;
                    inv_v_q <= inv_v_d;
                    if (!(tag_v_d || set_v_d || st_v_d || inv_v_d)) begin
                        bank_rdy_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (state_out_valid && bank_rdy_q) begin
                        rsp_state_q <= state_out;
                        state_vld_q <= 1'b1;
                    end
                    if (inv_ack_cnt_out_valid && bank_rdy_q) begin
                        rsp_inv_q <= inv_ack_cnt_out;
                        inv_vld_q <= 1'b1;
                    end
                    if (tag_out_evict_valid && bank_rdy_q) begin
                        ev_tag_q     <= tag_out_evict;
                        ev_seen_q[0] <= 1'b1;
                    end
                    if (set_out_evict_valid && bank_rdy_q) begin
                        ev_set_q     <= set_out_evict;
                        ev_seen_q[1] <= 1'b1;
                    end
                    if (state_out_evict_valid && bank_rdy_q) begin
                        ev_state_q   <= state_out_evict;
                        ev_seen_q[2] <= 1'b1;
                    end
                    if (way_out_valid && bank_rdy_q) begin
                        rsp_way_q   <= way_out;
                        bank_rdy_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_way_q   <= '0;
                        timeout_q   <= 1'b1;
                        bank_rdy_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FL_REQ: begin
                    if (flush_in_ready) begin
                        fl_v_q      <= 1'b0;
                        drain_rdy_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_FL_DRAIN;
                    end
                end
                S_FL_DRAIN: begin
                    // A record arriving alongside the completion is still counted.
                    if (way_out_flush_valid && drain_rdy_q && flush_cnt_q != 16'hFFFF) begin
                        flush_cnt_q <= flush_cnt_q + 16'd1;
                    end
                    if (flush_complete_valid && drain_rdy_q) begin
                        drain_rdy_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end else if (any_rec) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q   <= 1'b1;
                        drain_rdy_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_rec_rdy
            assign rec_ready[gi] = drain_rdy_q;
        end
    endgenerate

    assign {inv_ack_cnt_out_flush_ready, state_out_flush_ready, set_out_flush_ready,
            tag_out_flush_ready, way_out_flush_ready} = rec_ready;
    assign flush_complete_ready  = drain_rdy_q;

    assign cmd_ready             = cmd_ready_q;
    assign tag_in_valid          = tag_v_q;
    assign set_in_valid          = set_v_q;
    assign state_in_valid        = st_v_q;
    assign inv_ack_cnt_in_valid  = inv_v_q;
    assign tag_in                = tag_q;
    assign set_in                = set_q;
    assign state_in              = st_q;
    assign inv_ack_cnt_in        = inv_q;
    assign flush_in_valid        = fl_v_q;
    assign way_out_ready         = bank_rdy_q;
    assign state_out_ready       = bank_rdy_q;
    assign inv_ack_cnt_out_ready = bank_rdy_q;
    assign tag_out_evict_ready   = bank_rdy_q;
    assign set_out_evict_ready   = bank_rdy_q;
    assign state_out_evict_ready = bank_rdy_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_way               = rsp_way_q;
    assign rsp_state             = rsp_state_q;
    assign rsp_inv               = rsp_inv_q;
    assign rsp_state_vld         = state_vld_q;
    assign rsp_inv_vld           = inv_vld_q;
    assign rsp_evict             = &ev_seen_q;
    assign rsp_timeout           = timeout_q;
    assign rsp_evict_tag         = ev_tag_q;
    assign rsp_evict_set         = ev_set_q;
    assign rsp_evict_state       = ev_state_q;
    assign rsp_flush_cnt         = flush_cnt_q;
endmodule

// File: doc/l2_tag_lookup_initiator.md
Name: l2_tag_lookup_initiator

Overview:
- Requester side of the L2 cache tag bank flex-channel interface.
- Accepts one lookup or flush command from the L2 controller and drives the bank's tag/set/state/inv_ack_cnt input channels or its flush channel.
- Collects the bank's way, state, inv_ack_cnt and evict responses, or its flush records and flush completion, then returns a single response beat.
- Enforces one request in flight and a response timeout.

Parameters:
TAG_W, 20, tag width
SET_W, 8, set index width
WAY_W, 3, way index width
STATE_W, 2, coherence state width
INV_W, 4, inv_ack_cnt width
TIMEOUT, 64, max cycles waiting for way_out (must be ≥ 51; bank latency bound is 50)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid / cmd_ready  in / out  1  controller command handshake
cmd_flush  in  1  1 = flush command, 0 = lookup
cmd_tag, cmd_set  in  TAG_W, SET_W  lookup address
cmd_state_en, cmd_inv_en  in  1  send optional state / inv_ack_cnt channels
cmd_state, cmd_inv  in  STATE_W, INV_W  optional payloads
tag_in_valid / tag_in_ready / tag_in  out / in / out  1/1/TAG_W  bank tag channel
set_in_valid / set_in_ready / set_in  out / in / out  1/1/SET_W  bank set channel
state_in_valid / state_in_ready / state_in  out / in / out  1/1/STATE_W
inv_ack_cnt_in_valid / inv_ack_cnt_in_ready / inv_ack_cnt_in  out / in / out  1/1/INV_W
flush_in_valid / flush_in_ready  out / in  1  flush request
way_out_valid / way_out_ready / way_out  in / out / in  1/1/WAY_W
state_out_valid / state_out_ready / state_out  in / out / in  1/1/STATE_W
inv_ack_cnt_out_valid / inv_ack_cnt_out_ready / inv_ack_cnt_out  in / out / in  1/1/INV_W
{tag,set,state}_out_evict_valid / _ready / data  in / out / in  eviction victim channels
{way,tag,set,state,inv_ack_cnt}_out_flush_valid / _ready  in / out  1  flush record channels (data ignored)
flush_complete_valid / flush_complete_ready  in / out  1
rsp_valid / rsp_ready  out / in  1  response handshake
rsp_way, rsp_state, rsp_inv  out  WAY_W, STATE_W, INV_W  lookup result
rsp_state_vld, rsp_inv_vld, rsp_evict, rsp_timeout  out  1  result qualifiers
rsp_evict_tag, rsp_evict_set, rsp_evict_state  out  TAG_W, SET_W, STATE_W  victim
rsp_flush_cnt  out  16  records drained by the last flush

Behaviour:
- Reset:
  - All valid and ready outputs 0; all rsp_* 0; FSM in IDLE; counters 0.
  - rst asserted mid-operation aborts at the next edge. Nothing is replayed.
- FSM states: IDLE, ISSUE, WAIT, FL_REQ, FL_DRAIN, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd handshake, latch payload and go to ISSUE (cmd_flush = 0) or FL_REQ (cmd_flush = 1).
  - cmd_ready = 0 in every other state.
- ISSUE:
  - tag_in_valid and set_in_valid rise together on the first ISSUE cycle.
  - state_in_valid rises on that cycle only if cmd_state_en; inv_ack_cnt_in_valid only if cmd_inv_en.
  - Each valid is held, with stable data, until its own ready is sampled 1. It is 0 from the following cycle.
  - Go to WAIT once every enabled channel has handshaken.
  - No channel valid may re-rise before way_out is received.
- WAIT:
  - way_out_ready, state_out_ready, inv_ack_cnt_out_ready and the three evict readys are all 1.
  - state/inv/evict beats arriving in WAIT are latched and set their qualifier. rsp_evict requires the tag, set and state evict beats.
  - way_out handshake: latch rsp_way, go to RSP.
  - Wait counter increments each WAIT cycle. Reaching TIMEOUT → RSP with rsp_timeout = 1, rsp_way = 0.
- FL_REQ:
  - flush_in_valid held until flush_in_ready, then go to FL_DRAIN.
- FL_DRAIN:
  - All five flush-record readys and flush_complete_ready are 1.
  - rsp_flush_cnt increments per way_out_flush handshake and saturates at 0xFFFF.
  - flush_complete handshake → RSP.
  - The same cycle as a final record counts that record.
  - TIMEOUT idle cycles with no record or complete → RSP with rsp_timeout = 1.
- RSP:
  - rsp_valid = 1 with stable fields until rsp_ready, then go to IDLE.
  - Qualifiers clear on the next command accept.
- Latency: cmd accept → tag_in_valid next cycle. way_out handshake → rsp_valid next cycle.
- Unexpected bank beats (outside WAIT/FL_DRAIN) are not acknowledged (ready = 0).

Test Plan:
- Lookup, tag = 0x12345, set = 0x2A, no options, bank readys high, way_out = 5 after 10 cycles → tag/set valid for exactly 1 cycle; rsp_way = 5, rsp_state_vld = 0, rsp_timeout = 0; rsp_valid 1 cycle after way_out.
- Lookup with state = 2 and inv = 3; set_in_ready delayed 4 cycles; tag_in_ready immediate → tag valid drops after 1 cycle, set valid held 5 cycles with stable 0x2A; state/inv channels sent; no WAIT entry before set handshake.
- Lookup causing eviction: evict beats tag 0xABCDE, set 0x11, state 1, then way_out = 7 → rsp_evict = 1 with those fields, rsp_way = 7.
- No way_out for TIMEOUT = 64 cycles → rsp_timeout = 1, rsp_way = 0; next command accepted normally.
- Flush: 3 records then flush_complete; rsp_ready held low 5 cycles → rsp_flush_cnt = 3; rsp fields stable while stalled.
- rst pulsed in WAIT → all valids/readys 0 next cycle, FSM IDLE, cmd_ready = 1.
